// File: rtl/lorenz_pkg.sv
// Shared fixed-point format, FSM state type and arithmetic helpers for the
// parametrised Lorenz integrator.
package lorenz_pkg;

    localparam int WIDTH = 27;
    localparam int FRAC  = 20;

    // Signed WIDTH range expressed at the WIDTH+2 update width.
    localparam logic signed [WIDTH+1:0] STATE_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] STATE_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CALC,
        ST_UPDATE
    } state_t;

    // Full-precision product, sliced back to WIDTH+1 bits (floor toward -inf).
    function automatic logic signed [WIDTH:0] fx_mul(
        input logic signed [WIDTH:0] a,
        input logic signed [WIDTH:0] b
    );
        logic signed [2*WIDTH+1:0] ae;
        logic signed [2*WIDTH+1:0] be;
        logic signed [2*WIDTH+1:0] p;
        ae = {{(WIDTH+1){a[WIDTH]}}, a};
        be = {{(WIDTH+1){b[WIDTH]}}, b};
        p  = ae * be;
        return p[FRAC+WIDTH:FRAC];
    endfunction

    function automatic logic out_of_range(input logic signed [WIDTH+1:0] v);
        return (v > STATE_MAX) || (v < STATE_MIN);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_or_wrap(
        input logic signed [WIDTH+1:0] v,
        input logic                    sat
    );
        if (sat && (v > STATE_MAX)) return STATE_MAX[WIDTH-1:0];
        if (sat && (v < STATE_MIN)) return STATE_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lorenz_integrator_param_fx_mul.sv
// Signed fixed-point multiply with slice back to the derivative width.
module lorenz_fx_mul
    import lorenz_pkg::*;
(
    input  logic signed [WIDTH:0] a,
    input  logic signed [WIDTH:0] b,
    output logic signed [WIDTH:0] p
);

    assign p = fx_mul(a, b);

endmodule

// File: rtl/lorenz_integrator_param.sv
// Euler integrator for the Lorenz system with run-time coefficients, step-rate
// divider, initial-condition load, output freeze and saturate/wrap overflow.
module lorenz_integrator_param #(
    parameter int WIDTH    = 27,
    parameter int FRAC     = 20,
    parameter int DT_SHIFT = 8,
    parameter bit SATURATE = 1'b1,
    parameter int INIT_X   = -1048576,
    parameter int INIT_Y   = 104858,
    parameter int INIT_Z   = 26214400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] init_x,
    input  logic signed [WIDTH-1:0] init_y,
    input  logic signed [WIDTH-1:0] init_z,
    input  logic signed [WIDTH-1:0] sigma,
    input  logic signed [WIDTH-1:0] rho,
    input  logic signed [WIDTH-1:0] beta,
    input  logic [15:0]             rate_div,
    input  logic                    freeze,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    out_valid,
    output logic [31:0]             step_count,
    output logic                    ovf
);

    import lorenz_pkg::*;

    localparam logic signed [WIDTH-1:0] INIT_XW = WIDTH'(INIT_X);
    localparam logic signed [WIDTH-1:0] INIT_YW = WIDTH'(INIT_Y);
    localparam logic signed [WIDTH-1:0] INIT_ZW = WIDTH'(INIT_Z);

    state_t state;
    state_t state_next;

    logic [15:0]             cnt;
    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH:0]   dx, dy, dz;

    logic signed [WIDTH:0]   x_ext, y_ext, z_ext, sigma_ext, beta_ext;
    logic signed [WIDTH:0]   y_m_x, rho_m_z;
    logic signed [WIDTH:0]   p_sx, p_xr, p_xy, p_bz;
    logic signed [WIDTH:0]   dx_calc, dy_calc, dz_calc;
    logic signed [WIDTH:0]   dx_sh, dy_sh, dz_sh;
    logic signed [WIDTH+1:0] x_sum, y_sum, z_sum;
    logic signed [WIDTH-1:0] x_new, y_new, z_new;
    logic                    ovf_step;

    assign x_ext     = {x[WIDTH-1], x};
    assign y_ext     = {y[WIDTH-1], y};
    assign z_ext     = {z[WIDTH-1], z};
    assign sigma_ext = {sigma[WIDTH-1], sigma};
    assign beta_ext  = {beta[WIDTH-1], beta};
    assign y_m_x     = y_ext - x_ext;
    assign rho_m_z   = {rho[WIDTH-1], rho} - z_ext;

    lorenz_fx_mul u_mul_sx (.a(sigma_ext), .b(y_m_x),   .p(p_sx));
    lorenz_fx_mul u_mul_xr (.a(x_ext),     .b(rho_m_z), .p(p_xr));
    lorenz_fx_mul u_mul_xy (.a(x_ext),     .b(y_ext),   .p(p_xy));
    lorenz_fx_mul u_mul_bz (.a(beta_ext),  .b(z_ext),   .p(p_bz));

    assign dx_calc = p_sx;
    assign dy_calc = p_xr - y_ext;
    assign dz_calc = p_xy - p_bz;

    // Euler step: dt is a power of two, so the scale is an arithmetic shift.
    assign dx_sh = dx >>> DT_SHIFT;
    assign dy_sh = dy >>> DT_SHIFT;
    assign dz_sh = dz >>> DT_SHIFT;
    assign x_sum = {{2{x[WIDTH-1]}}, x} + {dx_sh[WIDTH], dx_sh};
    assign y_sum = {{2{y[WIDTH-1]}}, y} + {dy_sh[WIDTH], dy_sh};
    assign z_sum = {{2{z[WIDTH-1]}}, z} + {dz_sh[WIDTH], dz_sh};
    assign x_new = sat_or_wrap(x_sum, SATURATE);
    assign y_new = sat_or_wrap(y_sum, SATURATE);
    assign z_new = sat_or_wrap(z_sum, SATURATE);
    assign ovf_step = out_of_range(x_sum) | out_of_range(y_sum) | out_of_range(z_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (run) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!run)                 state_next = ST_IDLE;
                else if (cnt >= rate_div) state_next = ST_CALC;
            end
            ST_CALC:   state_next = ST_UPDATE;
            ST_UPDATE: state_next = run ? ST_WAIT : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // A load aborts whatever step is in flight.
        if (load) state_next = run ? ST_WAIT : ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            x          <= INIT_XW;
            y          <= INIT_YW;
            z          <= INIT_ZW;
            dx         <= '0;
            dy         <= '0;
            dz         <= '0;
            out_x      <= INIT_XW;
            out_y      <= INIT_YW;
            out_z      <= INIT_ZW;
            out_valid  <= 1'b0;
            step_count <= '0;
            ovf        <= 1'b0;
        end else if (load) begin
            cnt        <= '0;
            x          <= init_x;
            y          <= init_y;
            z          <= init_z;
            out_x      <= init_x;
            out_y      <= init_y;
            out_z      <= init_z;
            out_valid  <= 1'b0;
            step_count <= '0;
            ovf        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                ST_WAIT: begin
                    if (!run || (cnt >= rate_div)) cnt <= '0;
                    else                           cnt <= cnt + 16'd1;
                end
                ST_CALC: begin
                    dx <= dx_calc;
                    dy <= dy_calc;
                    dz <= dz_calc;
                end
                ST_UPDATE: begin
                    x   <= x_new;
                    y   <= y_new;
                    z   <= z_new;
                    ovf <= ovf | ovf_step;
                    if (!freeze) begin
                        out_x      <= x_new;
                        out_y      <= y_new;
                        out_z      <= z_new;
                        out_valid  <= 1'b1;
                        step_count <= step_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
